// File: rtl/stage_if_if.sv
// stage_if_if: instruction-memory req/gnt/rvalid bus between the fetch stage and imem.
interface stage_if_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/stage_if.sv
// stage_if: instruction fetch with predictor-steered PC, in-order fetch queue and redirect flush.
// FETCH_BYPASS_EN (optional macro) forwards a response straight to the head outputs in its rvalid cycle.
package stage_if_pkg;
    typedef logic [31:0] inst_t;
    localparam inst_t INST_NOP = 32'h0000_0013;
    typedef enum logic [1:0] {TRAP_NONE = 2'd0, TRAP_ENTER = 2'd1, TRAP_RETURN = 2'd2} trap_mode_e;
    localparam logic [4:0] CAUSE_INST_MISALIGNED   = 5'd0;
    localparam logic [4:0] CAUSE_INST_ACCESS_FAULT = 5'd1;
    typedef struct packed {
        logic        valid;
        trap_mode_e  mode;
        logic [4:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_req_t;
endpackage

module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              start,
    input  logic              stall_f,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       bp_pc,
    input  logic              bp_taken,
    input  logic [31:0]       bp_target,
    stage_if_if.master        imem,
    output logic              if_empty,
    output logic [31:0]       pc_f,
    output logic [31:0]       pcplus4_f,
    output logic [31:0]       pc_pred_f,
    output logic              pred_taken_f,
    output inst_t             inst_f,
    output trap_req_t         trap_req_f
);
    localparam int AW = $clog2(FETCH_DEPTH);
    localparam int DW = AW + 3;

    logic [31:0]   pc, next_pc;
    logic          halted;
    logic [AW:0]   count, n_unf;
    logic [AW-1:0] head, tail, fidx, idx;
    logic [DW-1:0] drop_cnt;
    logic [31:0]   q_pc     [FETCH_DEPTH];
    logic [31:0]   q_pred   [FETCH_DEPTH];
    logic          q_taken  [FETCH_DEPTH];
    logic          q_filled [FETCH_DEPTH];
    inst_t         q_inst   [FETCH_DEPTH];
    trap_req_t     q_trap   [FETCH_DEPTH];
    logic          found, can_alloc, push_req, push_mis, fill, fill_err, fbypass, head_ok, pop;
    trap_req_t     fill_trap, mis_trap, h_trap;
    inst_t         fill_inst, h_inst;

    // Fills go to the oldest unfilled entry; the unfilled total sizes the drop count on redirect.
    always_comb begin
        found = 1'b0;
        fidx  = head;
        idx   = head;
        n_unf = '0;
        for (int k = 0; k < FETCH_DEPTH; k++) begin
            idx = head + AW'(k);
            if ((AW+1)'(k) < count && !q_filled[idx]) begin
                if (!found) fidx = idx;
                found = 1'b1;
                n_unf = n_unf + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        can_alloc = start && !redirect_valid && !halted && count != (AW+1)'(FETCH_DEPTH);
        imem.req  = can_alloc && pc[1:0] == 2'b00;
        imem.addr = pc;
        bp_pc     = pc;
        push_req  = imem.req && imem.gnt;
        push_mis  = can_alloc && pc[1:0] != 2'b00;
        next_pc   = bp_taken ? bp_target : pc + 32'd4;
        fill      = imem.rvalid && drop_cnt == '0 && found;
        fill_err  = fill && imem.err;
        fill_inst = fill_err ? INST_NOP : imem.rdata;
        fill_trap = fill_err ? trap_req_t'{valid: 1'b1, mode: TRAP_ENTER, cause: CAUSE_INST_ACCESS_FAULT,
                                           pc: q_pc[fidx], tval: q_pc[fidx]} : '0;
        mis_trap  = trap_req_t'{valid: 1'b1, mode: TRAP_ENTER, cause: CAUSE_INST_MISALIGNED, pc: pc, tval: pc};
`ifdef FETCH_BYPASS_EN
        fbypass   = fill && fidx == head;
`else
        fbypass   = 1'b0;
`endif
        head_ok      = count != '0 && (q_filled[head] || fbypass);
        h_inst       = fbypass ? fill_inst : q_inst[head];
        h_trap       = fbypass ? fill_trap : q_trap[head];
        if_empty     = !head_ok;
        pc_f         = head_ok ? q_pc[head] : '0;
        pcplus4_f    = head_ok ? q_pc[head] + 32'd4 : '0;
        pc_pred_f    = head_ok ? q_pred[head] : '0;
        pred_taken_f = head_ok && q_taken[head];
        inst_f       = head_ok ? h_inst : INST_NOP;
        trap_req_f   = head_ok ? h_trap : '0;
        pop          = head_ok && !stall_f && !redirect_valid;
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            pc       <= RESET_PC;
            halted   <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            drop_cnt <= '0;
            for (int k = 0; k < FETCH_DEPTH; k++) begin
                q_pc[k]     <= '0;
                q_pred[k]   <= '0;
                q_taken[k]  <= 1'b0;
                q_filled[k] <= 1'b0;
                q_inst[k]   <= INST_NOP;
                q_trap[k]   <= '0;
            end
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            halted   <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            // Every response still in flight must be discarded, including drops already pending.
            drop_cnt <= drop_cnt + DW'(n_unf) - DW'(imem.rvalid);
        end else begin
            if (imem.rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - DW'(1);
            if (fill) begin
                q_filled[fidx] <= 1'b1;
                q_inst[fidx]   <= fill_inst;
                q_trap[fidx]   <= fill_trap;
            end
            if (push_req || push_mis) begin
                q_pc[tail]     <= pc;
                q_pred[tail]   <= push_mis ? pc + 32'd4 : next_pc;
                q_taken[tail]  <= push_req && bp_taken;
                q_filled[tail] <= push_mis;
                q_inst[tail]   <= INST_NOP;
                q_trap[tail]   <= push_mis ? mis_trap : '0;
                tail           <= tail + AW'(1);
            end
            if (push_req) pc <= next_pc;
            if (push_mis || fill_err) halted <= 1'b1;
            if (pop) head <= head + AW'(1);
            count <= count + (AW+1)'(push_req || push_mis) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed tests of stage_if against a one-cycle-latency imem model.
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clk = 1'b0;
    logic        start = 1'b1;
    logic        stall_f = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] bp_pc, bp_target, pc_f, pcplus4_f, pc_pred_f;
    logic        bp_taken, if_empty, pred_taken_f;
    inst_t       inst_f;
    trap_req_t   trap_req_f;
    logic        pred_en = 1'b0;
    logic [31:0] pred_pc = '0, pred_tgt = '0;
    logic        hold_rsp = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    logic        cap_v = 1'b0;
    logic [31:0] cap_a = '0;
    logic [31:0] pending[$], req_log[$], pop_pc[$];
    inst_t       pop_inst[$];
    int          vectors = 0, miscompares = 0;

    stage_if_if imem();

    stage_if dut (
        .clk(clk), .start(start), .stall_f(stall_f), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
        .imem(imem), .if_empty(if_empty), .pc_f(pc_f), .pcplus4_f(pcplus4_f),
        .pc_pred_f(pc_pred_f), .pred_taken_f(pred_taken_f), .inst_f(inst_f), .trap_req_f(trap_req_f)
    );

    always #5 clk = ~clk;
    assign bp_taken  = pred_en && bp_pc == pred_pc;
    assign bp_target = pred_tgt;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    // Requests granted in a cycle are answered in order, starting the next cycle.
    always @(posedge clk) begin
        if (!start) pending.delete();
        else if (cap_v) pending.push_back(cap_a);
        #1;
        if (start && !hold_rsp && pending.size() > 0) begin
            imem.rvalid = 1'b1;
            imem.rdata  = inst_of(pending[0]);
            imem.err    = pending[0] == err_addr;
            void'(pending.pop_front());
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = '0;
            imem.err    = 1'b0;
        end
    end

    always @(negedge clk) begin
        cap_v = imem.req && imem.gnt;
        cap_a = imem.addr;
        if (cap_v) req_log.push_back(imem.addr);
        if (start && !if_empty && !stall_f && !redirect_valid) begin
            pop_pc.push_back(pc_f);
            pop_inst.push_back(inst_f);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = a;
        pop_pc.delete();
        pop_inst.delete();
        neg();
        vectors++;
        if (imem.req !== 1'b0) begin miscompares++; $display("FAIL redir_req: got %b want 0", imem.req); end
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 start = 1'b0;
        #1;
        vectors += 7;
        if (imem.req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem.req); end
        if (if_empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", if_empty); end
        if (inst_f !== INST_NOP) begin miscompares++; $display("FAIL rst_inst: got %h want %h", inst_f, INST_NOP); end
        if (pc_f !== 32'h0 || pcplus4_f !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h/%h want 0/0", pc_f, pcplus4_f); end
        if (pc_pred_f !== 32'h0) begin miscompares++; $display("FAIL rst_pred: got %h want 0", pc_pred_f); end
        if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL rst_taken: got %b want 0", pred_taken_f); end
        if (trap_req_f !== '0) begin miscompares++; $display("FAIL rst_trap: got %h want 0", trap_req_f); end
        imem.gnt = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_fetch();
        pred_en = 1'b1; pred_pc = 32'h8; pred_tgt = 32'h100;
        req_log.delete(); pop_pc.delete(); pop_inst.delete();
        cyc();
        start = 1'b1;
        neg();
        vectors += 2;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin miscompares++; $display("FAIL fetch_a0: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
        if (if_empty !== 1'b1) begin miscompares++; $display("FAIL fetch_empty0: got %b want 1", if_empty); end
        cyc(); neg();
        vectors += 2;
        if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin miscompares++; $display("FAIL fetch_a4: got req=%b addr=%h want 1/4", imem.req, imem.addr); end
        if (if_empty !== 1'b1) begin miscompares++; $display("FAIL fetch_empty1: got %b want 1", if_empty); end
        cyc(); neg();
        vectors += 4;
        if (if_empty !== 1'b0) begin miscompares++; $display("FAIL fetch_head: got empty=%b want 0", if_empty); end
        if (pc_f !== 32'h0 || pcplus4_f !== 32'h4) begin miscompares++; $display("FAIL fetch_pc: got %h/%h want 0/4", pc_f, pcplus4_f); end
        if (inst_f !== 32'h13) begin miscompares++; $display("FAIL fetch_inst: got %h want 13", inst_f); end
        if (pc_pred_f !== 32'h4 || pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL fetch_pred: got %h/%b want 4/0", pc_pred_f, pred_taken_f); end
    endtask

    task automatic test_branch();
        logic        seen = 1'b0;
        logic [31:0] exp_seq [4] = '{32'h0, 32'h4, 32'h8, 32'h100};
        for (int i = 0; i < 20; i++) begin
            cyc(); neg();
            if (!seen && !if_empty && pc_f == 32'h8) begin
                seen = 1'b1;
                vectors++;
                if (pred_taken_f !== 1'b1 || pc_pred_f !== 32'h100 || pcplus4_f !== 32'hC) begin
                    miscompares++;
                    $display("FAIL br_head: got taken=%b pred=%h p4=%h want 1/100/c", pred_taken_f, pc_pred_f, pcplus4_f);
                end
            end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL br_seen: head 0x8 got never want seen"); end
        for (int i = 0; i < 4; i++) begin
            vectors += 2;
            if (req_log.size() <= i || req_log[i] !== exp_seq[i]) begin
                miscompares++; $display("FAIL br_req[%0d]: got %h want %h", i, req_log.size() > i ? req_log[i] : 32'hDEAD_BEEF, exp_seq[i]);
            end
            if (pop_pc.size() <= i || pop_pc[i] !== exp_seq[i]) begin
                miscompares++; $display("FAIL br_pop[%0d]: got %h want %h", i, pop_pc.size() > i ? pop_pc[i] : 32'hDEAD_BEEF, exp_seq[i]);
            end
        end
        pred_en = 1'b0;
    endtask

    task automatic test_redirect();
        logic ok = 1'b0;
        hold_rsp = 1'b1;
        for (int i = 0; i < 12 && !ok; i++) begin
            cyc(); neg();
            ok = !imem.req && if_empty;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rd_fill: got not full-unfilled want full-unfilled"); end
        redirect_to(32'h200);
        hold_rsp = 1'b0;
        neg();
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin miscompares++; $display("FAIL rd_a200: got req=%b addr=%h want 1/200", imem.req, imem.addr); end
        for (int i = 0; i < 15 && pop_pc.size() < 2; i++) begin cyc(); neg(); end
        vectors += 2;
        if (pop_pc.size() < 2) begin
            miscompares += 2; $display("FAIL rd_pops: got %0d heads want 2", pop_pc.size());
        end else begin
            if (pop_pc[0] !== 32'h200 || pop_inst[0] !== inst_of(32'h200)) begin miscompares++; $display("FAIL rd_head0: got %h/%h want 200/%h", pop_pc[0], pop_inst[0], inst_of(32'h200)); end
            if (pop_pc[1] !== 32'h204 || pop_inst[1] !== inst_of(32'h204)) begin miscompares++; $display("FAIL rd_head1: got %h/%h want 204/%h", pop_pc[1], pop_inst[1], inst_of(32'h204)); end
        end
    endtask

    task automatic test_gnt_wait();
        pred_en = 1'b1; pred_pc = 32'h500; pred_tgt = 32'h600;
        imem.gnt = 1'b0;
        redirect_to(32'h500);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            neg();
            vectors++;
            if (imem.req !== 1'b1 || imem.addr !== 32'h500) begin miscompares++; $display("FAIL gw_hold%0d: got req=%b addr=%h want 1/500", i, imem.req, imem.addr); end
        end
        cyc(); imem.gnt = 1'b1; neg();
        cyc(); neg();
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h600) begin miscompares++; $display("FAIL gw_tgt: got req=%b addr=%h want 1/600", imem.req, imem.addr); end
        pred_en = 1'b0;
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        neg();
        cyc(); neg();
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin miscompares++; $display("FAIL wrap: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
    endtask

    task automatic test_misaligned();
        int reqs = 0;
        trap_req_t exp = '{valid: 1'b1, mode: TRAP_ENTER, cause: CAUSE_INST_MISALIGNED, pc: 32'h202, tval: 32'h202};
        stall_f = 1'b1;
        redirect_to(32'h202);
        neg();
        vectors++;
        if (imem.req !== 1'b0) begin miscompares++; $display("FAIL mis_req: got %b want 0", imem.req); end
        cyc(); neg();
        vectors += 3;
        if (if_empty !== 1'b0) begin miscompares++; $display("FAIL mis_empty: got %b want 0", if_empty); end
        if (trap_req_f !== exp) begin miscompares++; $display("FAIL mis_trap: got %h want %h", trap_req_f, exp); end
        if (inst_f !== INST_NOP || pc_f !== 32'h202) begin miscompares++; $display("FAIL mis_head: got %h/%h want %h/202", inst_f, pc_f, INST_NOP); end
        cyc();
        stall_f = 1'b0;
        for (int i = 0; i < 6; i++) begin
            neg();
            if (imem.req) reqs++;
            cyc();
        end
        neg();
        vectors += 2;
        if (reqs != 0) begin miscompares++; $display("FAIL mis_halt: got %0d requests want 0", reqs); end
        if (if_empty !== 1'b1) begin miscompares++; $display("FAIL mis_drain: got %b want 1", if_empty); end
    endtask

    task automatic test_access_fault();
        logic ok = 1'b0;
        int reqs = 0;
        trap_req_t exp = '{valid: 1'b1, mode: TRAP_ENTER, cause: CAUSE_INST_ACCESS_FAULT, pc: 32'h40, tval: 32'h40};
        err_addr = 32'h40;
        stall_f = 1'b1;
        redirect_to(32'h40);
        for (int i = 0; i < 10 && !ok; i++) begin
            if (i > 0) cyc();
            neg();
            ok = !if_empty;
        end
        vectors += 3;
        if (!ok || trap_req_f !== exp) begin miscompares++; $display("FAIL af_trap: got %h want %h", trap_req_f, exp); end
        if (inst_f !== INST_NOP || pc_f !== 32'h40) begin miscompares++; $display("FAIL af_head: got %h/%h want %h/40", inst_f, pc_f, INST_NOP); end
        if (imem.req !== 1'b0) begin miscompares++; $display("FAIL af_req: got %b want 0", imem.req); end
        cyc(); stall_f = 1'b0; neg();
        cyc(); neg();
        vectors += 2;
        if (if_empty !== 1'b0 || pc_f !== 32'h44 || inst_f !== inst_of(32'h44)) begin
            miscompares++; $display("FAIL af_young: got e=%b %h/%h want 0 44/%h", if_empty, pc_f, inst_f, inst_of(32'h44));
        end
        if (trap_req_f !== '0) begin miscompares++; $display("FAIL af_young_trap: got %h want 0", trap_req_f); end
        for (int i = 0; i < 4; i++) begin cyc(); neg(); if (imem.req) reqs++; end
        vectors++;
        if (reqs != 0) begin miscompares++; $display("FAIL af_halt: got %0d requests want 0", reqs); end
        err_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_back_to_back();
        stall_f = 1'b1;
        redirect_to(32'h300);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            neg();
            if (i >= 2) begin
                vectors++;
                if ({imem.req, if_empty, pc_f, inst_f} !== {1'b0, 1'b0, 32'h300, inst_of(32'h300)}) begin
                    miscompares++; $display("FAIL stall%0d: got req=%b e=%b pc=%h inst=%h want 0/0/300/%h", i, imem.req, if_empty, pc_f, inst_f, inst_of(32'h300));
                end
            end
        end
        cyc(); stall_f = 1'b0;
        for (int i = 0; i < 16; i++) begin neg(); cyc(); end
        vectors++;
        if (pop_pc.size() < 6) begin miscompares++; $display("FAIL b2b_count: got %0d heads want >=6", pop_pc.size()); end
        for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
            vectors++;
            if (pop_pc[i] !== 32'h300 + 32'(4 * i) || pop_inst[i] !== inst_of(32'h300 + 32'(4 * i))) begin
                miscompares++; $display("FAIL b2b[%0d]: got %h/%h want %h/%h", i, pop_pc[i], pop_inst[i], 32'h300 + 32'(4 * i), inst_of(32'h300 + 32'(4 * i)));
            end
        end
    endtask

    initial begin
        imem.gnt = 1'b0;
        test_reset();
        test_fetch();
        test_branch();
        test_redirect();
        test_gnt_wait();
        test_wrap();
        test_misaligned();
        test_access_fault();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1);
    end
endmodule
